mem_access_ctrl: RTL and testbench

Sequencing controller for the 64-bit byte-addressed data memory (one synchronous read port, one write port, 8-byte access at any byte address). It arbitrates between the instruction-fetch requester and the load/store requester. It performs read-modify-write for byte, half and word stores, and extracts and extends load data. It sits between the CPU control unit/datapath and the memory instance.

---
 rtl/mem_access_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: arbitrates instruction fetch and load/store traffic onto a
// single-read/single-write 64-bit memory. Sub-doubleword stores are performed
// as read-modify-write; load data is extracted and sign/zero-extended.
module mem_access_ctrl #(
    parameter int RD_LAT = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_req,
    input  logic [63:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_done,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [1:0]  d_size,
    input  logic        d_unsigned,
    input  logic [63:0] d_addr,
    input  logic [63:0] d_wdata,
    output logic [63:0] d_rdata,
    output logic        d_done,
    output logic [63:0] mem_raddr,
    output logic [63:0] mem_waddr,
    output logic [63:0] mem_wdata,
    output logic        mem_write,
    input  logic [63:0] mem_rdata
);

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_WRITE, S_DONE} state_t;

    localparam logic [2:0] CNT_INIT = 3'(RD_LAT - 1);

    state_t      state_q, state_d;
    logic        last_gnt_q, last_gnt_d;   // 1 = data was granted last
    logic        owner_q, owner_d;         // 1 = data requester owns the op
    logic [63:0] addr_q, addr_d;
    logic [1:0]  size_q, size_d;
    logic        uns_q, uns_d;
    logic        we_q, we_d;
    logic [63:0] wdata_q, wdata_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [63:0] rbuf_q, rbuf_d;
    logic [31:0] if_rdata_q, if_rdata_d;
    logic [63:0] d_rdata_q, d_rdata_d;
    logic        if_done_q, if_done_d;
    logic        d_done_q, d_done_d;
    logic        grant_data;
    logic        dw_store;

    // Extract the low 1/2/4/8 bytes of the captured dword and extend to 64 bits.
    function automatic logic [63:0] load_ext(input logic [63:0] dw, input logic [1:0] sz,
                                             input logic uns);
        logic signed [63:0] s;
        unique case (sz)
            2'd0:    s = {{56{dw[7]  & ~uns}}, dw[7:0]};
            2'd1:    s = {{48{dw[15] & ~uns}}, dw[15:0]};
            2'd2:    s = {{32{dw[31] & ~uns}}, dw[31:0]};
            default: s = dw;
        endcase
        return s;
    endfunction

    // Replace the low N bytes of the old dword with store data; upper bytes kept.
    function automatic logic [63:0] merge_store(input logic [63:0] old, input logic [63:0] wd,
                                                input logic [1:0] sz);
        logic [63:0] m;
        unique case (sz)
            2'd0:    m = {old[63:8],  wd[7:0]};
            2'd1:    m = {old[63:16], wd[15:0]};
            2'd2:    m = {old[63:32], wd[31:0]};
            default: m = wd;
        endcase
        return m;
    endfunction

    // On a conflict the requester not granted last wins; lone requests win outright.
    assign grant_data = d_req && (!if_req || !last_gnt_q);
    assign dw_store   = we_q && (size_q == 2'd3);

    // State register and all latched operands/results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            last_gnt_q <= 1'b0;
            owner_q    <= 1'b0;
            addr_q     <= '0;
            size_q     <= '0;
            uns_q      <= 1'b0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            cnt_q      <= '0;
            rbuf_q     <= '0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
            if_done_q  <= 1'b0;
            d_done_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_gnt_q <= last_gnt_d;
            owner_q    <= owner_d;
            addr_q     <= addr_d;
            size_q     <= size_d;
            uns_q      <= uns_d;
            we_q       <= we_d;
            wdata_q    <= wdata_d;
            cnt_q      <= cnt_d;
            rbuf_q     <= rbuf_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
            if_done_q  <= if_done_d;
            d_done_q   <= d_done_d;
        end
    end

    // Next-state sequencing: accept, issue read, wait latency, optional RMW write, done.
    always_comb begin
        state_d    = state_q;
        last_gnt_d = last_gnt_q;
        owner_d    = owner_q;
        addr_d     = addr_q;
        size_d     = size_q;
        uns_d      = uns_q;
        we_d       = we_q;
        wdata_d    = wdata_q;
        cnt_d      = cnt_q;
        rbuf_d     = rbuf_q;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;
        if_done_d  = 1'b0;
        d_done_d   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (d_req || if_req) begin
                    owner_d    = grant_data;
                    last_gnt_d = grant_data;
                    addr_d     = grant_data ? d_addr : if_addr;
                    size_d     = grant_data ? d_size : 2'd2;
                    uns_d      = d_unsigned;
                    we_d       = grant_data && d_we;
                    wdata_d    = d_wdata;
                    state_d    = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (dw_store) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d   = CNT_INIT;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q == 3'd0) begin
                    rbuf_d  = mem_rdata;
                    state_d = we_q ? S_WRITE : S_DONE;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            S_WRITE: begin
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
                if (owner_q) begin
                    d_done_d = 1'b1;
                    if (!we_q) begin
                        d_rdata_d = load_ext(rbuf_q, size_q, uns_q);
                    end
                end else begin
                    if_done_d  = 1'b1;
                    if_rdata_d = rbuf_q[31:0];
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Memory-side outputs decoded from registered state and latched operands only.
    always_comb begin
        mem_raddr = (state_q != S_IDLE) ? addr_q : 64'd0;
        mem_write = ((state_q == S_ISSUE) && dw_store) || (state_q == S_WRITE);
        mem_waddr = mem_write ? addr_q : 64'd0;
        mem_wdata = 64'd0;
        if (state_q == S_WRITE) begin
            mem_wdata = merge_store(rbuf_q, wdata_q, size_q);
        end else if ((state_q == S_ISSUE) && dw_store) begin
            mem_wdata = wdata_q;
        end
    end

    assign if_rdata = if_rdata_q;
    assign d_rdata  = d_rdata_q;
    assign if_done  = if_done_q;
    assign d_done   = d_done_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: a byte-array memory model with RD_LAT
// read pipeline, directed fetch/load/store vectors, and a negedge monitor.
module tb_mem_access_ctrl;
    localparam int RD_LAT = 1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req, d_req, d_we, d_unsigned;
    logic [63:0] if_addr, d_addr, d_wdata;
    logic [1:0]  d_size;
    logic [31:0] if_rdata;
    logic        if_done, d_done;
    logic [63:0] d_rdata, mem_raddr, mem_waddr, mem_wdata, mem_rdata;
    logic        mem_write;

    mem_access_ctrl #(.RD_LAT(RD_LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
        .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_unsigned(d_unsigned),
        .d_addr(d_addr), .d_wdata(d_wdata), .d_rdata(d_rdata), .d_done(d_done),
        .mem_raddr(mem_raddr), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .mem_write(mem_write), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: 4 KiB byte array, read sampled at edge, data RD_LAT cycles later.
    logic [7:0]  mem [0:4095];
    logic [63:0] rd_pipe [0:RD_LAT-1];
    assign mem_rdata = rd_pipe[RD_LAT-1];

    function automatic logic [63:0] peek(input logic [63:0] a);
        logic [63:0] d;
        for (int i = 0; i < 8; i++) d[8*i +: 8] = mem[12'(a + 64'(i))];
        return d;
    endfunction

    task automatic poke(input logic [63:0] a, input logic [63:0] d);
        for (int i = 0; i < 8; i++) mem[12'(a + 64'(i))] = d[8*i +: 8];
    endtask

    always @(posedge clk) begin
        rd_pipe[0] <= peek(mem_raddr);
        for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
        if (mem_write) poke(mem_waddr, mem_wdata);
    end

    typedef struct {
        bit          is_data;
        logic [63:0] rdata;
        bit          chk;
        int          exp_cyc;
    } exp_t;
    typedef struct {
        logic [63:0] addr;
        logic [63:0] data;
    } wexp_t;

    exp_t  sb [$];
    wexp_t wq [$];
    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: every done pulse and every memory write is matched against the queues.
    initial begin
        exp_t  e;
        wexp_t w;
        forever begin
            @(negedge clk);
            if (d_done || if_done) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", {62'd0, d_done, if_done}, 64'd0);
                end else begin
                    e = sb.pop_front();
                    check("done_owner", {62'd0, d_done, if_done}, e.is_data ? 64'd2 : 64'd1);
                    if (e.chk) begin
                        if (e.is_data) check("d_rdata", d_rdata, e.rdata);
                        else           check("if_rdata", {32'd0, if_rdata}, e.rdata);
                    end
                    if (e.exp_cyc >= 0) check("latency", 64'(cyc), 64'(e.exp_cyc));
                end
            end
            if (mem_write) begin
                if (wq.size() == 0) begin
                    check("unexpected_write", {63'd0, mem_write}, 64'd0);
                end else begin
                    w = wq.pop_front();
                    check("mem_waddr", mem_waddr, w.addr);
                    check("mem_wdata", mem_wdata, w.data);
                end
            end
        end
    end

    task automatic wait_done(input bit is_data);
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (is_data ? d_done : if_done) return;
        end
        check("done_timeout", 64'd1, 64'd0);
    endtask

    task automatic data_op(input bit we, input logic [1:0] sz, input bit uns,
                           input logic [63:0] a, input logic [63:0] wd,
                           input logic [63:0] exp_rd, input bit chk, input int lat,
                           input bit push);
        exp_t e;
        @(negedge clk);
        d_req = 1'b1; d_we = we; d_size = sz; d_unsigned = uns; d_addr = a; d_wdata = wd;
        if (push) begin
            e = '{1'b1, exp_rd, chk, (lat >= 0) ? cyc + 1 + lat : -1};
            sb.push_back(e);
        end
        wait_done(1'b1);
        d_req = 1'b0;
    endtask

    task automatic fetch_op(input logic [63:0] a, input logic [63:0] exp_rd,
                            input int lat, input bit push);
        exp_t e;
        @(negedge clk);
        if_req = 1'b1; if_addr = a;
        if (push) begin
            e = '{1'b0, exp_rd, 1'b1, (lat >= 0) ? cyc + 1 + lat : -1};
            sb.push_back(e);
        end
        wait_done(1'b0);
        if_req = 1'b0;
    endtask

    function automatic exp_t mk(input bit is_data, input logic [63:0] rd);
        exp_t e;
        e = '{is_data, rd, 1'b1, -1};
        return e;
    endfunction

    initial begin
        rst_n = 1'b0;
        for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
        poke(64'h100, 64'h0000_0000_0050_0513);      // fetch bytes 13 05 50 00
        mem[12'h040] = 8'h80;                         // byte 0x80 at 0x40
        poke(64'h048, 64'h0000_0000_8000_0000);      // word 0x80000000 at 0x48
        poke(64'h203, 64'h1122_3344_5566_7788);
        poke(64'h300, 64'h0123_4567_89AB_CDEF);
        poke(64'h500, 64'h0102_0304_0506_0708);

        // Reset held with random inputs: all outputs must read zero.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if_req = 1'($urandom); d_req = 1'($urandom); d_we = 1'($urandom);
            d_size = 2'($urandom); d_unsigned = 1'($urandom);
            if_addr = {32'd0, $urandom}; d_addr = {32'd0, $urandom};
            d_wdata = {$urandom, $urandom};
        end
        #1;
        check("rst_if_rdata", {32'd0, if_rdata}, 64'd0);
        check("rst_d_rdata", d_rdata, 64'd0);
        check("rst_dones", {62'd0, if_done, d_done}, 64'd0);
        check("rst_mem_write", {63'd0, mem_write}, 64'd0);
        check("rst_mem_raddr", mem_raddr, 64'd0);
        check("rst_mem_waddr", mem_waddr, 64'd0);
        check("rst_mem_wdata", mem_wdata, 64'd0);
        @(negedge clk);
        if_req = 1'b0; d_req = 1'b0; d_we = 1'b0; d_size = 2'd0; d_unsigned = 1'b0;
        if_addr = '0; d_addr = '0; d_wdata = '0;
        rst_n = 1'b1;

        // First conflict after reset: data wins, then fetch.
        sb.push_back(mk(1'b1, 64'h0000_0000_0000_0080));
        sb.push_back(mk(1'b0, 64'h0000_0000_0050_0513));
        fork
            data_op(1'b0, 2'd3, 1'b0, 64'h40, 64'd0, 64'd0, 1'b0, -1, 1'b0);
            fetch_op(64'h100, 64'd0, -1, 1'b0);
        join

        // Lone fetch, latency 2+RD_LAT.
        fetch_op(64'h100, 64'h0000_0000_0050_0513, 2 + RD_LAT, 1'b1);

        // Continuous conflict after a fetch grant: data, fetch, data.
        sb.push_back(mk(1'b1, 64'h0000_0000_0000_0080));
        sb.push_back(mk(1'b0, 64'h0000_0000_0050_0513));
        sb.push_back(mk(1'b1, 64'hFFFF_FFFF_8000_0000));
        fork
            begin
                data_op(1'b0, 2'd0, 1'b1, 64'h40, 64'd0, 64'd0, 1'b0, -1, 1'b0);
                data_op(1'b0, 2'd2, 1'b0, 64'h48, 64'd0, 64'd0, 1'b0, -1, 1'b0);
            end
            fetch_op(64'h100, 64'd0, -1, 1'b0);
        join

        // Load extension.
        data_op(1'b0, 2'd0, 1'b0, 64'h40, 64'd0, 64'hFFFF_FFFF_FFFF_FF80, 1'b1, 2 + RD_LAT, 1'b1);
        data_op(1'b0, 2'd0, 1'b1, 64'h40, 64'd0, 64'h0000_0000_0000_0080, 1'b1, 2 + RD_LAT, 1'b1);
        data_op(1'b0, 2'd2, 1'b0, 64'h48, 64'd0, 64'hFFFF_FFFF_8000_0000, 1'b1, 2 + RD_LAT, 1'b1);
        data_op(1'b0, 2'd2, 1'b1, 64'h48, 64'd0, 64'h0000_0000_8000_0000, 1'b1, 2 + RD_LAT, 1'b1);

        // Unaligned byte store via RMW, then read back.
        wq.push_back('{64'h203, 64'h1122_3344_5566_77AB});
        data_op(1'b1, 2'd0, 1'b0, 64'h203, 64'hDEAD_BEEF_CAFE_12AB, 64'd0, 1'b0, 3 + RD_LAT, 1'b1);
        data_op(1'b0, 2'd3, 1'b0, 64'h203, 64'd0, 64'h1122_3344_5566_77AB, 1'b1, 2 + RD_LAT, 1'b1);

        // Half and word stores keep upper bytes; halfword load sign-extends.
        wq.push_back('{64'h500, 64'h0102_0304_0506_BEEF});
        data_op(1'b1, 2'd1, 1'b0, 64'h500, 64'hFFFF_FFFF_FFFF_BEEF, 64'd0, 1'b0, 3 + RD_LAT, 1'b1);
        wq.push_back('{64'h500, 64'h0102_0304_DEAD_BEEF});
        data_op(1'b1, 2'd2, 1'b0, 64'h500, 64'hAAAA_AAAA_DEAD_BEEF, 64'd0, 1'b0, 3 + RD_LAT, 1'b1);
        data_op(1'b0, 2'd1, 1'b0, 64'h500, 64'd0, 64'hFFFF_FFFF_FFFF_BEEF, 1'b1, 2 + RD_LAT, 1'b1);

        // Doubleword store writes directly from ISSUE.
        wq.push_back('{64'h601, 64'hCAFE_F00D_1234_5678});
        data_op(1'b1, 2'd3, 1'b0, 64'h601, 64'hCAFE_F00D_1234_5678, 64'd0, 1'b0, 2, 1'b1);
        data_op(1'b0, 2'd3, 1'b1, 64'h601, 64'd0, 64'hCAFE_F00D_1234_5678, 1'b1, 2 + RD_LAT, 1'b1);

        // Reset during WAIT of a halfword store: no write, no done, back to IDLE.
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b1; d_size = 2'd1; d_unsigned = 1'b0;
        d_addr = 64'h300; d_wdata = 64'h0000_0000_0000_BBBB;
        @(negedge clk);
        check("issue_raddr", mem_raddr, 64'h300);
        @(negedge clk);
        rst_n = 1'b0;
        d_req = 1'b0;
        #1;
        check("rst_mid_write", {63'd0, mem_write}, 64'd0);
        check("rst_mid_raddr", mem_raddr, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("post_rst_idle", mem_raddr, 64'd0);
        check("mem_unchanged", peek(64'h300), 64'h0123_4567_89AB_CDEF);
        data_op(1'b0, 2'd3, 1'b0, 64'h300, 64'd0, 64'h0123_4567_89AB_CDEF, 1'b1, 2 + RD_LAT, 1'b1);

        repeat (4) @(negedge clk);
        check("sb_drained", 64'(sb.size()), 64'd0);
        check("wq_drained", 64'(wq.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end
endmodule
